// File: rtl/tagger_pkg.sv
// Shared definitions for the tagger record path: record/word widths and the
// output word-index state, plus the word selector used by the serializer.
package tagger_pkg;

    localparam int RECORD_W         = 47;
    localparam int STORED_W         = 48;
    localparam int WORD_W           = 16;
    localparam int WORDS_PER_RECORD = 3;

    typedef enum logic [1:0] {
        S_W0 = 2'd0,
        S_W1 = 2'd1,
        S_W2 = 2'd2
    } word_idx_e;

    // Most significant word goes out first.
    function automatic logic [WORD_W-1:0] select_word(
        input logic [STORED_W-1:0] rec,
        input word_idx_e           idx
    );
        logic [WORD_W-1:0] w;
        w = rec[STORED_W-1 -: WORD_W];
        case (idx)
            S_W0:    w = rec[47:32];
            S_W1:    w = rec[31:16];
            S_W2:    w = rec[15:0];
            default: w = rec[47:32];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/record_serializer_if.sv
// Word stream from the record serializer to the host-interface FIFO:
// valid/ready handshake carrying one 16-bit word per transfer.
interface record_serializer_if;
    import tagger_pkg::*;

    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count and a combinational
// head read (rd_data shows the oldest entry whenever empty is low).
module sync_fifo #(
    parameter  int WIDTH = 48,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; pointers and count
    // make its contents don't-care until written, and a reset would stop it
    // mapping onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/record_serializer.sv
// Captures strobed 47-bit records into a FIFO, tags each with a lost-record
// flag and streams it out as three 16-bit words over a valid/ready link.
module record_serializer
    import tagger_pkg::*;
#(
    parameter  int DEPTH  = 16,
    parameter  int LOST_W = 16,
    localparam int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                data_rdy,
    input  logic [RECORD_W-1:0] data,
    record_serializer_if.master link,
    output logic [LVL_W-1:0]    fifo_level,
    output logic [LOST_W-1:0]   lost_count,
    output logic                overflow
);

    logic [STORED_W-1:0] head;
    logic                full;
    logic                empty;
    logic                handshake;
    logic                pop;
    logic                accept;
    logic                pending_loss;
    word_idx_e           word_idx;

    assign handshake = !empty && link.out_ready;
    assign pop       = handshake && (word_idx == S_W2);
    // A full FIFO still takes the record when its head leaves on this edge.
    assign accept    = data_rdy && (!full || pop);

    sync_fifo #(
        .WIDTH (STORED_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (accept),
        .wr_data ({pending_loss, data}),
        .rd_en   (pop),
        .rd_data (head),
        .count   (fifo_level),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            word_idx     <= S_W0;
            pending_loss <= 1'b0;
            lost_count   <= '0;
            overflow     <= 1'b0;
        end else begin
            if (handshake) begin
                case (word_idx)
                    S_W0:    word_idx <= S_W1;
                    S_W1:    word_idx <= S_W2;
                    default: word_idx <= S_W0;
                endcase
            end
            if (data_rdy && !accept) begin
                overflow     <= 1'b1;
                pending_loss <= 1'b1;
                if (lost_count != '1) lost_count <= lost_count + LOST_W'(1);
            end else if (accept) begin
                pending_loss <= 1'b0;
            end
        end
    end

    // Count is registered, so valid is a clean registered level; data is
    // forced to zero while idle so nothing stale leaks onto the link.
    assign link.out_valid = !empty;
    assign link.out_data  = empty ? '0 : select_word(head, word_idx);

endmodule
